// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM; optional addi path under MC_ADDI_EN
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

`ifdef MC_ADDI_EN
  localparam logic ADDI_EN = 1'b1;
`else
  localparam logic ADDI_EN = 1'b0;
`endif

  logic [3:0] next_state;
  logic       legal_op;

  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW: legal_op = 1'b1;
      OP_ADDI:                              legal_op = ADDI_EN;
      default:                              legal_op = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = ADDI_EN ? S_ADDIEX : S_FETCH;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      next_state = S_MEMRD;
        else if (opcode == OP_SW) next_state = S_MEMWR;
        else                      next_state = S_FETCH;
      end
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_RWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      // Without the addi path, encodings 11/12 behave like any unused code.
      S_ADDIEX: next_state = ADDI_EN ? S_ADDIWB : S_IDLE;
      S_ADDIWB: next_state = ADDI_EN ? S_FETCH : S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC and IR only latch once the fetch actually returns data.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        illegal = ~legal_op;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = ADDI_EN;
        ALUSrcB = ADDI_EN ? 2'b10 : 2'b00;
      end
      S_ADDIWB: RegWrite = ADDI_EN;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench for multicycle_control; addi checks follow MC_ADDI_EN
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic [16:0] ctl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal(illegal), .state(state)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal}
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};

  localparam logic [16:0] C_ZERO    = 17'b0;
  localparam logic [16:0] C_FETCH   = 17'b1_0_0_1_0_0_1_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FETCHW  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_DECILL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_1_0_1_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_0_1_0_0_00_00_00_0;
  localparam logic [16:0] C_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

  task automatic test_reset();
    mem_ready = 1'b1;
    opcode = 6'd35;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got %0d expected 0", state);
    end
    checks++;
    if (ctl !== C_ZERO) begin
      failures++;
      $display("FAIL reset_ctl got %b expected %b", ctl, C_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0]  es [$] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [16:0] ec [$] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB};
    opcode = 6'd35;
    for (int i = 0; i < es.size(); i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      checks++;
      if (state !== es[i]) begin
        failures++;
        $display("FAIL lw_state[%0d] got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctl !== ec[i]) begin
        failures++;
        $display("FAIL lw_ctl[%0d] got %b expected %b", i, ctl, ec[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  es [$] = '{4'd1, 4'd2, 4'd7, 4'd8};
    logic [16:0] ec [$] = '{C_FETCH, C_DECODE, C_EXEC, C_RWB};
    opcode = 6'd0;
    for (int i = 0; i < es.size(); i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      checks++;
      if (state !== es[i]) begin
        failures++;
        $display("FAIL rtype_state[%0d] got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctl !== ec[i]) begin
        failures++;
        $display("FAIL rtype_ctl[%0d] got %b expected %b", i, ctl, ec[i]);
      end
    end
  endtask

  task automatic test_beq_j();
    logic [5:0]  op [$] = '{6'd4, 6'd4, 6'd4, 6'd2, 6'd2, 6'd2};
    logic [3:0]  es [$] = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10};
    logic [16:0] ec [$] = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH, C_DECODE, C_JUMP};
    for (int i = 0; i < es.size(); i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      opcode = op[i];
      #1;
      checks++;
      if (state !== es[i]) begin
        failures++;
        $display("FAIL beq_j_state[%0d] got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctl !== ec[i]) begin
        failures++;
        $display("FAIL beq_j_ctl[%0d] got %b expected %b", i, ctl, ec[i]);
      end
    end
  endtask

  task automatic test_sw_stall();
    logic        mr [$] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  es [$] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd6, 4'd6};
    logic [16:0] ec [$] = '{C_FETCHW, C_FETCHW, C_FETCH, C_DECODE, C_MEMADR,
                            C_MEMWR, C_MEMWR, C_MEMWR, C_MEMWR};
    opcode = 6'd43;
    for (int i = 0; i < es.size(); i++) begin
      @(negedge clk);
      mem_ready = mr[i];
      #1;
      checks++;
      if (state !== es[i]) begin
        failures++;
        $display("FAIL sw_state[%0d] got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctl !== ec[i]) begin
        failures++;
        $display("FAIL sw_ctl[%0d] got %b expected %b", i, ctl, ec[i]);
      end
    end
  endtask

  task automatic test_addi();
`ifdef MC_ADDI_EN
    logic [5:0]  op [$] = '{6'd8, 6'd8, 6'd8, 6'd8, 6'd63, 6'd63, 6'd0};
    logic [3:0]  es [$] = '{4'd1, 4'd2, 4'd11, 4'd12, 4'd1, 4'd2, 4'd1};
    logic [16:0] ec [$] = '{C_FETCH, C_DECODE, C_MEMADR, C_ADDIWB, C_FETCH, C_DECILL, C_FETCH};
`else
    logic [5:0]  op [$] = '{6'd8, 6'd8, 6'd63, 6'd63, 6'd0};
    logic [3:0]  es [$] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
    logic [16:0] ec [$] = '{C_FETCH, C_DECILL, C_FETCH, C_DECILL, C_FETCH};
`endif
    for (int i = 0; i < es.size(); i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      opcode = op[i];
      #1;
      checks++;
      if (state !== es[i]) begin
        failures++;
        $display("FAIL addi_state[%0d] got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctl !== ec[i]) begin
        failures++;
        $display("FAIL addi_ctl[%0d] got %b expected %b", i, ctl, ec[i]);
      end
    end
    // The trailing FETCH entry above was sampled with mem_ready=1 and leaves DECODE next.
    @(negedge clk);
  endtask

  task automatic test_reset_mid_memrd();
    logic        mr [$] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  es [$] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [16:0] ec [$] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD};
    opcode = 6'd35;
    // Realign to FETCH: the previous task ended in DECODE of an R-type.
    opcode = 6'd0;
    repeat (3) @(negedge clk);
    opcode = 6'd35;
    for (int i = 0; i < es.size(); i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mr[i];
      #1;
      checks++;
      if (state !== es[i]) begin
        failures++;
        $display("FAIL rst_mid_state[%0d] got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctl !== ec[i]) begin
        failures++;
        $display("FAIL rst_mid_ctl[%0d] got %b expected %b", i, ctl, ec[i]);
      end
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || ctl !== C_ZERO) begin
      failures++;
      $display("FAIL rst_async got state=%0d ctl=%b expected state=0 ctl=%b", state, ctl, C_ZERO);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || ctl !== C_ZERO) begin
      failures++;
      $display("FAIL rst_held got state=%0d ctl=%b expected state=0 ctl=%b", state, ctl, C_ZERO);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd1 || ctl !== C_FETCH) begin
      failures++;
      $display("FAIL rst_release got state=%0d ctl=%b expected state=1 ctl=%b", state, ctl, C_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq_j();
    test_sw_stall();
    test_addi();
    test_reset_mid_memrd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
